rr_arb_mux: RTL and testbench



---
 rtl/rr_arb_mux_pkg.sv | 20 ++
 rtl/rr_arb_mux_if.sv | 30 +++
 rtl/rr_arb_mux_arbiter.sv | 89 ++++++++
 rtl/rr_arb_mux.sv | 81 ++++++++
 tb/tb_rr_arb_mux.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/rr_arb_mux_pkg.sv
// Shared constants and helpers for the rr_arb_mux round-robin arbitrating mux.
// Optional packet locking is enabled with the RR_ARB_MUX_PKT_LOCK_EN macro.
package rr_arb_mux_pkg;

  localparam int unsigned DEF_BUS_COUNT = 4;
  localparam int unsigned DEF_BUS_WIDTH = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

  // Width of a binary channel index for the default channel count.
  localparam int unsigned DEF_IDX_W = clog2(DEF_BUS_COUNT);

endpackage

// File: rtl/rr_arb_mux_if.sv
// Valid/ready bundle between the input channels, rr_arb_mux and its consumer.
// The slave modport is the mux side; the master modport drives channels and out_ready.
interface rr_arb_mux_if
  import rr_arb_mux_pkg::*;
#(
  parameter int unsigned bus_count = DEF_BUS_COUNT,
  parameter int unsigned bus_width = DEF_BUS_WIDTH
);

  logic [bus_count*bus_width-1:0] in_data;
  logic [bus_count-1:0]           in_valid;
  logic [bus_count-1:0]           in_last;
  logic [bus_count-1:0]           in_ready;
  logic [bus_width-1:0]           out_data;
  logic                           out_valid;
  logic                           out_last;
  logic [bus_count-1:0]           out_grant;
  logic                           out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_grant
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, out_grant
  );

endinterface

// File: rtl/rr_arb_mux_arbiter.sv
// Round-robin arbiter: one-hot priority pointer and circular first-one search.
// With RR_ARB_MUX_PKT_LOCK_EN defined, the grant is held until a last beat is accepted.
module rr_arbiter
  import rr_arb_mux_pkg::*;
#(
  parameter int unsigned bus_count = DEF_BUS_COUNT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [bus_count-1:0] req,
  input  logic [bus_count-1:0] last,
  input  logic                 advance,
  output logic [bus_count-1:0] gnt
);

  logic [bus_count-1:0]   ptr_q, ptr_d;
  logic [bus_count-1:0]   elig;
  logic [bus_count-1:0]   gnt_rot;
  logic [2*bus_count-1:0] dbl_req;
  logic [2*bus_count-1:0] dbl_gnt;

  // Subtracting the pointer from the doubled request clears every request below
  // it; the lowest surviving bit is the first requester at or above the pointer.
  always_comb begin
    dbl_req = {elig, elig};
    dbl_gnt = dbl_req & ~(dbl_req - {{bus_count{1'b0}}, ptr_q});
    gnt     = dbl_gnt[bus_count-1:0] | dbl_gnt[2*bus_count-1:bus_count];
    gnt_rot = {gnt[bus_count-2:0], gnt[bus_count-1]};
  end

`ifdef RR_ARB_MUX_PKT_LOCK_EN
  logic                 locked_q, locked_d;
  logic [bus_count-1:0] owner_q, owner_d;
  logic                 win_last;

  assign elig = locked_q ? (req & owner_q) : req;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    locked_d = locked_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    win_last = |(last & gnt);
    if (advance) begin
      if (win_last) begin
        locked_d = 1'b0;
        ptr_d    = gnt_rot;
      end else begin
        locked_d = 1'b1;
        owner_d  = gnt;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= {{(bus_count-1){1'b0}}, 1'b1};
      locked_q <= 1'b0;
      owner_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      locked_q <= locked_d;
      owner_q  <= owner_d;
    end
  end
`else
  logic unused_last;

  assign elig        = req;
  assign unused_last = ^last;

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = gnt_rot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= {{(bus_count-1){1'b0}}, 1'b1};
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

endmodule

// File: rtl/rr_arb_mux.sv
// Registered round-robin arbitrating mux merging bus_count valid/ready streams into one.
// Packet locking in the arbiter is enabled by defining RR_ARB_MUX_PKT_LOCK_EN.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int unsigned bus_count = DEF_BUS_COUNT,
  parameter int unsigned bus_width = DEF_BUS_WIDTH
) (
  input logic         clk,
  input logic         rst_n,
  rr_arb_mux_if.slave bus
);

  logic                 load;
  logic                 advance;
  logic [bus_count-1:0] gnt;
  logic [bus_width-1:0] sel_data;

  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic [bus_width-1:0] data_q, data_d;
  logic [bus_count-1:0] grant_q, grant_d;

  // The register may reload whenever it is empty or being drained this cycle.
  assign load         = !valid_q || bus.out_ready;
  assign advance      = load && (|gnt);
  assign bus.in_ready = load ? gnt : '0;

  rr_arbiter #(
    .bus_count (bus_count)
  ) u_arbiter (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.in_valid),
    .last    (bus.in_last),
    .advance (advance),
    .gnt     (gnt)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < int'(bus_count); i++) begin
      sel_data = sel_data | (bus.in_data[bus_width*i +: bus_width] & {bus_width{gnt[i]}});
    end
  end

  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    grant_d = grant_q;
    if (advance) begin
      valid_d = 1'b1;
      last_d  = |(bus.in_last & gnt);
      data_d  = sel_data;
      grant_d = gnt;
    end else if (load) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
      grant_q <= grant_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.out_data  = data_q;
  assign bus.out_grant = grant_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux: accepted beats are predicted by a round-robin
// reference model and compared when they appear at the registered output.
module tb_rr_arb_mux;

  localparam int N = 4;
  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
    logic [N-1:0] grant;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  rr_arb_mux_if #(.bus_count(N), .bus_width(W)) bus ();

  rr_arb_mux #(.bus_count(N), .bus_width(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  beat_t        exp_q[$];
  beat_t        held;
  int           n_checks = 0;
  int           n_pass   = 0;
  int           m_ptr;
  bit           m_out_valid;
  bit           m_locked;
  int           m_owner;
  logic [N-1:0] acc_mask;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  task automatic model_reset();
    m_ptr       = 0;
    m_out_valid = 1'b0;
    m_locked    = 1'b0;
    m_owner     = 0;
    acc_mask    = '0;
    held        = '0;
    exp_q.delete();
  endtask

  // Index of the winning channel, or -1 when nothing is eligible.
  function automatic int pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
      if (m_locked && idx != m_owner) continue;
`endif
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    int           w;
    bit           ld;
    logic [N-1:0] exp_rdy;
    beat_t        b;
    #1;
    ld      = !m_out_valid || bus.out_ready;
    w       = pick(bus.in_valid);
    exp_rdy = '0;
    if (ld && w >= 0) exp_rdy[w] = 1'b1;
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    acc_mask = exp_rdy;
    if (ld && w >= 0) begin
      b.data  = bus.in_data[W*w +: W];
      b.last  = bus.in_last[w];
      b.grant = exp_rdy;
      exp_q.push_back(b);
`ifdef RR_ARB_MUX_PKT_LOCK_EN
      if (bus.in_last[w]) begin
        m_locked = 1'b0;
        m_ptr    = (w + 1) % N;
      end else begin
        m_locked = 1'b1;
        m_owner  = w;
      end
`else
      m_ptr = (w + 1) % N;
`endif
      m_out_valid = 1'b1;
    end else if (ld) begin
      m_out_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(m_out_valid));
    if (ld && w >= 0) begin
      held = exp_q.pop_front();
      check("out_data", 32'(bus.out_data), 32'(held.data));
      check("out_grant", 32'(bus.out_grant), 32'(held.grant));
      check("out_last", 32'(bus.out_last), 32'(held.last));
    end else if (m_out_valid) begin
      check("hold_data", 32'(bus.out_data), 32'(held.data));
    end
    @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] exp_g;
    int           sent;

    rst_n         = 1'b0;
    bus.in_valid  = '0;
    bus.in_last   = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_grant", 32'(bus.out_grant), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_out_last", 32'(bus.out_last), 0);
    check("rst_in_ready", 32'(bus.in_ready), 0);

    for (int k = 0; k < 3; k++) begin
      step();
      check("idle_grant", 32'(bus.out_grant), 0);
    end

    // All channels valid, data equals channel index, single-beat packets.
    bus.in_valid = 4'b1111;
    bus.in_last  = 4'b1111;
    bus.in_data  = {4'd3, 4'd2, 4'd1, 4'd0};
    for (int k = 0; k < 8; k++) begin
      step();
      exp_g = 4'b0001 << (k % 4);
      check("rr_grant", 32'(bus.out_grant), 32'(exp_g));
      check("rr_data", 32'(bus.out_data), 32'(k % 4));
    end

    // Only channel 2: grant it, then again with the pointer parked at bit 3.
    bus.in_valid = 4'b0100;
    bus.in_data  = {4'd3, 4'd5, 4'd1, 4'd0};
    step();
    step();
    check("wrap_grant", 32'(bus.out_grant), 32'h4);
    bus.in_valid = 4'b1111;
    step();
    check("ptr_after_wrap", 32'(bus.out_grant), 32'h8);

    // Stall three cycles with a beat held, then release.
    bus.out_ready = 1'b0;
    repeat (3) begin
      step();
      check("stall_data", 32'(bus.out_data), 32'd3);
    end
    bus.out_ready = 1'b1;
    step();
    check("release_grant", 32'(bus.out_grant), 32'h1);

    // Packet of three beats on channel 1 while channel 0 stays valid.
    bus.in_valid = 4'b0001;
    bus.in_last  = 4'b0001;
    step();
    bus.in_valid = 4'b0011;
    sent = 0;
    for (int k = 0; k < 10 && sent < 3; k++) begin
      bus.in_data[7:4] = 4'(4'hA + sent);
      bus.in_last[1]   = (sent == 2);
      step();
`ifdef RR_ARB_MUX_PKT_LOCK_EN
      check("lock_grant", 32'(bus.out_grant), 32'h2);
`endif
      if (acc_mask[1]) sent++;
    end
    check("lock_sent", 32'(sent), 32'd3);
    bus.in_valid = 4'b0001;
    step();
    check("after_lock_grant", 32'(bus.out_grant), 32'h1);

    // Random traffic from protocol-respecting sources with random backpressure.
    for (int k = 0; k < 300; k++) begin
      for (int c = 0; c < N; c++) begin
        if (!bus.in_valid[c] || acc_mask[c]) begin
          bus.in_valid[c]        = 1'($urandom_range(0, 1));
          bus.in_last[c]         = 1'($urandom_range(0, 1));
          bus.in_data[W*c +: W]  = W'($urandom);
        end
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Reset in the middle of traffic.
    bus.in_valid  = 4'b1111;
    bus.in_last   = 4'b1111;
    bus.in_data   = {4'd3, 4'd2, 4'd1, 4'd0};
    bus.out_ready = 1'b1;
    step();
    step();
    check("pre_rst_valid", 32'(bus.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 0);
    check("async_rst_grant", 32'(bus.out_grant), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_grant", 32'(bus.out_grant), 32'h1);
    step();
    check("post_rst_grant2", 32'(bus.out_grant), 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
